alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Iterative unsigned 32x32->64 multiply sequencer that time-shares the single-cycle ALU as its adder. Accepts one operand pair per request and runs a shift-add loop of 32 ALU additions, one per clock. Drives the ALU operand and opcode inputs directly. Reads back Result and CarryOut to build the 64-bit product. Sits beside the integer datapath as the backing engine for unsigned MUL/MULHU.

## Interface
Parameters: none; widths fixed at 32 data / 4 ALU opcode.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while ready=1
- op_a  in  32  multiplicand, captured on accepted start
- op_b  in  32  multiplier, captured on accepted start
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; product valid
- product_lo  out  32  product bits [31:0], held until next accepted start
- product_hi  out  32  product bits [63:32], held until next accepted start
- alu_a  out  32  to ALU operand A
- alu_b  out  32  to ALU operand B
- alu_op  out  4  to ALU opcode; always 4'b0000 (add)
- alu_result  in  32  from ALU Result
- alu_carry  in  1  from ALU CarryOut (valid for add)

## Operation
- Registers: mcand[31:0], hi[31:0], lo[31:0] (product-low / remaining multiplier), cnt[4:0], state.
- States:
  - IDLE: ready=1. start=1 -> capture mcand=op_a, lo=op_b, hi=0, cnt=0 -> RUN.
  - RUN: ready=0. Each cycle, alu_a=hi and alu_b = lo[0] ? mcand : 32'h0.
    - Update {hi,lo} <= {alu_carry&lo[0], alu_result, lo[31:1]}; the 65-bit value is shifted right by 1 and the low bit is dropped.
    - cnt increments. At cnt==31 the update is applied and the state moves to DONE.
  - DONE: done=1 for exactly this cycle. product_hi/product_lo <= hi/lo on entry. Next state is IDLE unconditionally.
- Outside RUN: alu_a=alu_b=0. alu_op=0000 in every state.
- Start while not IDLE (RUN or DONE) is ignored, with no side effects.
- Arithmetic is unsigned and modulo 2^64 is never reached (max product 0xFFFFFFFE_00000001). Carry uses the ALU CarryOut only; no local adder.

## Timing
- Reset (async assert): state=IDLE, ready=1, done=0, product_hi=product_lo=0, alu_a=alu_b=0, alu_op=0, cnt=0, internal regs 0.
- Reset deassertion is synchronised by the instantiating level; the block takes no action on rising rst_n.
- Reset mid-RUN aborts immediately. Outputs take reset values and no done pulse is issued.
- Latency: start accepted at edge E0. RUN spans cycles E0+1..E0+32. done=1 in cycle E0+33. ready returns high in cycle E0+34.
- Minimum start-to-start interval is 34 cycles.
- Product outputs change only on entry to DONE. They are stable from the done cycle until the next DONE.

## Configuration
- MUL_ZERO_BYPASS_EN defined: a start with op_a==0 or op_b==0 goes IDLE->DONE directly.
  - product_hi=product_lo=0 and done=1 in cycle E0+1. RUN is skipped and the ALU is not driven.
- Undefined: zero operands take the full 32-cycle RUN, with done at E0+33 and a product of 0.

## Test plan
- op_a=3, op_b=5, start one cycle -> done at E0+33, product_hi=0, product_lo=15; ready low E0+1..E0+33.
- op_a=op_b=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001; checks the ALU carry path.
- op_a=0x80000000, op_b=2 -> product_hi=1, product_lo=0. Then pulse start with new operands at E0+10 and E0+33 -> both ignored; product unchanged; exactly one done pulse.
- Start 0x1234*0x5678, assert rst_n=0 at E0+15 -> same-cycle outputs at reset values, no done pulse. After release, 7*6 -> product_lo=42 at E0'+33.
- op_a=0, op_b=0x1234 -> done at E0+1 with product 0 if MUL_ZERO_BYPASS_EN is defined; done at E0+33 with product 0 otherwise.
- 200 random operand pairs back-to-back (start asserted whenever ready=1) -> each {product_hi,product_lo} equals the 64-bit reference product. alu_op is 0 on every cycle.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Iterative unsigned 32x32->64 shift-add multiplier that borrows the shared ALU as its adder.
// Build option MUL_ZERO_BYPASS_EN: a zero operand skips the RUN loop and completes in one cycle.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] product_lo_o,
    output logic [31:0] product_hi_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_op_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_carry_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] mcand_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt_q;
    logic        ready_q;
    logic        done_q;
    logic [31:0] prod_hi_q;
    logic [31:0] prod_lo_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;

    logic [31:0] hi_d;
    logic [31:0] lo_d;
    logic        zero_op_s;

    // One shift-add step: {carry, sum, lo} shifted right by one with the old lo[0] dropped
    always_comb begin
        hi_d = {alu_carry_i & lo_q[0], alu_result_i[31:1]};
        lo_d = {alu_result_i[0], lo_q[31:1]};
`ifdef MUL_ZERO_BYPASS_EN
        zero_op_s = (op_a_i == 32'd0) || (op_b_i == 32'd0);
`else
        zero_op_s = 1'b0;
`endif
    end

    // Sequencer FSM; ALU operands are registered one cycle ahead so they match hi/lo in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            cnt_q     <= 5'd0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            prod_hi_q <= 32'd0;
            prod_lo_q <= 32'd0;
            alu_a_q   <= 32'd0;
            alu_b_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q  <= 1'b0;
                    alu_a_q <= 32'd0;
                    alu_b_q <= 32'd0;
                    if (start_i) begin
                        mcand_q <= op_a_i;
                        hi_q    <= 32'd0;
                        lo_q    <= op_b_i;
                        cnt_q   <= 5'd0;
                        ready_q <= 1'b0;
                        if (zero_op_s) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            prod_hi_q <= 32'd0;
                            prod_lo_q <= 32'd0;
                        end else begin
                            state_q <= S_RUN;
                            alu_b_q <= op_b_i[0] ? op_a_i : 32'd0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        prod_hi_q <= hi_d;
                        prod_lo_q <= lo_d;
                        alu_a_q   <= 32'd0;
                        alu_b_q   <= 32'd0;
                    end else begin
                        state_q <= S_RUN;
                        done_q  <= 1'b0;
                        alu_a_q <= hi_d;
                        alu_b_q <= lo_d[0] ? mcand_q : 32'd0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    alu_a_q <= 32'd0;
                    alu_b_q <= 32'd0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    alu_a_q <= 32'd0;
                    alu_b_q <= 32'd0;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign done_o       = done_q;
    assign product_hi_o = prod_hi_q;
    assign product_lo_o = prod_lo_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = 4'b0000;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and random bench for alu_mul_seq with a behavioural ALU and a product scoreboard.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        ready;
    logic        done;
    logic [31:0] product_lo;
    logic [31:0] product_hi;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_carry;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    // ALU stand-in: adds for opcode 0000, subtracts otherwise so a wrong opcode corrupts results
    assign {alu_carry, alu_result} = (alu_op == 4'b0000) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                                         : ({1'b0, alu_a} - {1'b0, alu_b});

    alu_mul_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .ready_o      (ready),
        .done_o       (done),
        .product_lo_o (product_lo),
        .product_hi_o (product_hi),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .alu_carry_i  (alu_carry)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        check("alu_op", {60'd0, alu_op}, 64'd0);
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        while (ready !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        check("ready_before_start", {63'd0, ready}, 64'd1);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        exp_q.push_back({32'd0, a} * {32'd0, b});
        tick();
        start = 1'b0;
    endtask

    // n = cycles after the accepting edge until done is seen (0 = done in the first cycle)
    task automatic wait_done(input int already, output int n);
        n = already;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int n, input int exp_lat);
        logic [63:0] e;
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_product"}, {product_hi, product_lo}, e);
        end else begin
            check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;

        // reset state
        #12;
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", {product_hi, product_lo}, 64'd0);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_alu_op", {60'd0, alu_op}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // 3 * 5, including the first two ALU operand cycles
        do_start(32'd3, 32'd5);
        check("t1_ready_low", {63'd0, ready}, 64'd0);
        check("t1_alu_c0", {alu_a, alu_b}, {32'd0, 32'd3});
        tick();
        check("t1_alu_c1", {alu_a, alu_b}, {32'd1, 32'd0});
        wait_done(1, n);
        check("t1_ready_in_done", {63'd0, ready}, 64'd0);
        check("t1_alu_idle_ab", {alu_a, alu_b}, 64'd0);
        check_result("t1", n, 32);
        check("t1_product_lo", {32'd0, product_lo}, 64'd15);
        tick();
        check("t1_ready_back", {63'd0, ready}, 64'd1);
        check("t1_done_clear", {63'd0, done}, 64'd0);

        // all-ones operands exercise the carry path
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, n);
        check_result("t2", n, 32);
        check("t2_value", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);

        // starts during RUN and DONE are ignored
        tick();
        do_start(32'h8000_0000, 32'd2);
        done_cnt = 0;
        repeat (9) tick();
        op_a = 32'hDEAD_BEEF; op_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (21) tick();
        tick();
        check_result("t3", 32, 32);
        check("t3_value", {product_hi, product_lo}, 64'h0000_0001_0000_0000);
        op_a = 32'h0BAD_F00D; op_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_ready_after", {63'd0, ready}, 64'd1);
        repeat (5) tick();
        check("t3_still_idle", {63'd0, ready}, 64'd1);
        check("t3_one_done", 64'(done_cnt), 64'd1);
        check("t3_product_held", {product_hi, product_lo}, 64'h0000_0001_0000_0000);

        // reset in the middle of RUN
        do_start(32'h1234, 32'h5678);
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        check("t4_rst_ready", {63'd0, ready}, 64'd1);
        check("t4_rst_done", {63'd0, done}, 64'd0);
        check("t4_rst_product", {product_hi, product_lo}, 64'd0);
        check("t4_rst_alu_ab", {alu_a, alu_b}, 64'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        done_cnt = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("t4_no_done", 64'(done_cnt), 64'd0);
        check("t4_idle", {63'd0, ready}, 64'd1);
        do_start(32'd7, 32'd6);
        wait_done(0, n);
        check_result("t4b", n, 32);
        check("t4b_value", {32'd0, product_lo}, 64'd42);

        // zero operand
`ifdef MUL_ZERO_BYPASS_EN
        lat = 0;
`else
        lat = 32;
`endif
        do_start(32'd0, 32'h1234);
        check("t5_alu_ab", {alu_a, alu_b}, 64'd0);
        wait_done(0, n);
        check_result("t5", n, lat);

        // random back-to-back operands
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
`ifdef MUL_ZERO_BYPASS_EN
            lat = (ra == 32'd0 || rb == 32'd0) ? 0 : 32;
`else
            lat = 32;
`endif
            do_start(ra, rb);
            wait_done(0, n);
            check_result("rand", n, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
